// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory system (slave).
// Request/grant/response handshake with word address, byte enables and data in both directions.
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_address_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    modport master (
        output mem_req_o,
        output mem_address_o,
        output mem_we_o,
        output mem_data_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_address_o,
        input  mem_we_o,
        input  mem_data_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_data_i
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory instruction from execute, runs it on the req/gnt/rvalid
// bus while stalling upstream, and reports completion, misalignment or bus timeout as pulses.
package lsu_pkg;
    typedef enum logic [3:0] {
        LB, LBU, LH, LHU, LW, LR_W, SB, SH, SW, SC_W, NOP
    } iType_e;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     valid_i,
    input  iType_e                   instruction_operation_i,
    input  logic [31:0]              address_i,
    input  logic [31:0]              store_data_i,
    input  logic                     sc_allow_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    load_store_unit_if.master        bus,
    output logic                     done_o,
    output logic [31:0]              load_data_o,
    output logic                     misaligned_o,
    output logic                     access_fault_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    localparam logic [CNT_W-1:0] TO_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TO_ENABLE = (TIMEOUT_CYCLES != 0);

    function automatic logic is_load(input iType_e op);
        return op inside {LB, LBU, LH, LHU, LW, LR_W};
    endfunction

    function automatic logic is_store(input iType_e op);
        return op inside {SB, SH, SW, SC_W};
    endfunction

    function automatic logic misaligned(input iType_e op, input logic [1:0] a);
        case (op)
            LH, LHU, SH:        return a[0];
            LW, LR_W, SW, SC_W: return a != 2'b00;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_we(input iType_e op, input logic [1:0] a);
        case (op)
            SB:       return 4'b0001 << a;
            SH:       return 4'b0011 << {a[1], 1'b0};
            SW, SC_W: return 4'hF;
            default:  return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input iType_e op, input logic [31:0] d);
        case (op)
            SB:       return {4{d[7:0]}};
            SH:       return {2{d[15:0]}};
            SW, SC_W: return d;
            default:  return 32'h0;
        endcase
    endfunction

    state_e           state_p1, state_p0;
    logic             abort_p1, abort_p0;
    logic [CNT_W-1:0] cnt_p1, cnt_p0;
    logic             done_p0, mis_p0, fault_p0, capture_p0;

    logic [31:0]      addr_p1, wdata_p1, load_data_p1;
    logic [3:0]       we_p1;
    logic             is_load_p1, done_p1, mis_p1, fault_p1;

    logic             op_mem, op_misal, sc_fail, accept, start;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit, killed;

    // Stage p0: decode and accept of the execute request
    assign op_mem      = is_load(instruction_operation_i) | is_store(instruction_operation_i);
    assign op_misal    = misaligned(instruction_operation_i, address_i[1:0]);
    assign sc_fail     = (instruction_operation_i == SC_W) && !sc_allow_i;
    assign accept      = (state_p1 == S_IDLE) && valid_i && op_mem && !op_misal;
    assign start       = accept && !sc_fail;
    assign cnt_inc     = cnt_p1 + CNT_W'(1);
    assign timeout_hit = TO_ENABLE && (cnt_inc == TO_LIMIT);
    assign killed      = abort_p1 | flush_i;

    always_comb begin
        state_p0   = state_p1;
        abort_p0   = abort_p1;
        cnt_p0     = cnt_p1;
        done_p0    = 1'b0;
        mis_p0     = 1'b0;
        fault_p0   = 1'b0;
        capture_p0 = 1'b0;
        case (state_p1)
            S_IDLE: begin
                abort_p0 = 1'b0;
                if (valid_i && op_mem && op_misal) begin
                    mis_p0 = 1'b1;
                end else if (accept) begin
                    if (sc_fail) begin
                        done_p0 = 1'b1;
                    end else begin
                        state_p0 = S_REQ;
                        cnt_p0   = '0;
                    end
                end
            end
            S_REQ: begin
                cnt_p0 = cnt_inc;
                if (flush_i && !bus.mem_gnt_i) begin
                    state_p0 = S_IDLE;
                end else if (timeout_hit) begin
                    // A flushed access that also times out is dropped silently
                    state_p0 = S_IDLE;
                    fault_p0 = !flush_i;
                end else if (bus.mem_gnt_i) begin
                    state_p0 = S_WAIT;
                    abort_p0 = flush_i;
                end
            end
            S_WAIT: begin
                cnt_p0 = cnt_inc;
                if (bus.mem_rvalid_i) begin
                    state_p0   = S_IDLE;
                    done_p0    = !killed;
                    capture_p0 = !killed && is_load_p1;
                end else begin
                    if (flush_i) abort_p0 = 1'b1;
                    if (timeout_hit) begin
                        state_p0 = S_IDLE;
                        fault_p0 = !killed;
                    end
                end
            end
            default: state_p0 = S_IDLE;
        endcase
    end

    // Stage p1: FSM state, abort flag and timeout counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p1 <= S_IDLE;
            abort_p1 <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            state_p1 <= state_p0;
            abort_p1 <= abort_p0;
            cnt_p1   <= cnt_p0;
        end
    end

    // Stage p1: bus operands, response capture and event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_p1      <= '0;
            we_p1        <= '0;
            wdata_p1     <= '0;
            is_load_p1   <= 1'b0;
            load_data_p1 <= '0;
            done_p1      <= 1'b0;
            mis_p1       <= 1'b0;
            fault_p1     <= 1'b0;
        end else begin
            done_p1  <= done_p0;
            mis_p1   <= mis_p0;
            fault_p1 <= fault_p0;
            if (start) begin
                addr_p1    <= {address_i[31:2], 2'b00};
                we_p1      <= store_we(instruction_operation_i, address_i[1:0]);
                wdata_p1   <= store_data(instruction_operation_i, store_data_i);
                is_load_p1 <= is_load(instruction_operation_i);
            end
            if (capture_p0) load_data_p1 <= bus.mem_data_i;
        end
    end

    assign stall_o           = (state_p1 != S_IDLE) || accept;
    assign bus.mem_req_o     = (state_p1 == S_REQ);
    assign bus.mem_address_o = addr_p1;
    assign bus.mem_we_o      = we_p1;
    assign bus.mem_data_o    = wdata_p1;
    assign done_o            = done_p1;
    assign load_data_o       = load_data_p1;
    assign misaligned_o      = mis_p1;
    assign access_fault_o    = fault_p1;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random transactions checked against a
// transaction-level model of alignment, store formatting, latency, flush and timeout.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, valid, valid2, sc_allow, flush;
    iType_e      op;
    logic [31:0] addr, wdata;
    logic        stall, done, mis, fault;
    logic        stall2, done2, mis2, fault2;
    logic [31:0] ld, ld2;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_ld = 32'h0;

    always #5 clk = ~clk;

    load_store_unit_if bus ();
    load_store_unit_if bus2 ();

    load_store_unit dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid), .instruction_operation_i(op),
        .address_i(addr), .store_data_i(wdata), .sc_allow_i(sc_allow), .flush_i(flush),
        .stall_o(stall), .bus(bus), .done_o(done), .load_data_o(ld),
        .misaligned_o(mis), .access_fault_o(fault)
    );

    load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid2), .instruction_operation_i(op),
        .address_i(addr), .store_data_i(wdata), .sc_allow_i(sc_allow), .flush_i(flush),
        .stall_o(stall2), .bus(bus2), .done_o(done2), .load_data_o(ld2),
        .misaligned_o(mis2), .access_fault_o(fault2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_load(input iType_e o);
        return (o == LB) || (o == LBU) || (o == LH) || (o == LHU) || (o == LW) || (o == LR_W);
    endfunction

    function automatic bit m_store(input iType_e o);
        return (o == SB) || (o == SH) || (o == SW) || (o == SC_W);
    endfunction

    function automatic bit m_misal(input iType_e o, input logic [31:0] a);
        int size;
        if (o == LB || o == LBU || o == SB)      size = 1;
        else if (o == LH || o == LHU || o == SH) size = 2;
        else                                     size = 4;
        return (a % 32'(size)) != 0;
    endfunction

    function automatic logic [3:0] m_we(input iType_e o, input logic [31:0] a);
        if (o == SB) return 4'(1 << (a % 4));
        if (o == SH) return 4'(3 << (a & 32'd2));
        if (o == SW || o == SC_W) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] m_wd(input iType_e o, input logic [31:0] d);
        if (o == SB) return (d & 32'hFF) * 32'h01010101;
        if (o == SH) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    // fmode: 0 none, 1 flush in first REQ cycle, 2 flush in first WAIT cycle
    task automatic do_txn(input iType_e o, input logic [31:0] a, input logic [31:0] d,
                          input logic sca, input int gdel, input int rdel,
                          input logic [31:0] rdata, input int fmode);
        bit mem, mal, scf, aborted, cancelled;
        mem = m_load(o) || m_store(o);
        mal = mem && m_misal(o, a);
        scf = (o == SC_W) && !sca;
        aborted = 0;
        cancelled = 0;
        step();
        op = o; addr = a; wdata = d; sc_allow = sca; valid = 1'b1;
        #1;
        chkb("stall_accept", stall, mem && !mal);
        step();
        valid = 1'b0;
        #1;
        if (!mem) begin
            chkb("ign_req", bus.mem_req_o, 1'b0);
            chkb("ign_stall", stall, 1'b0);
            chkb("ign_done", done, 1'b0);
            chkb("ign_mis", mis, 1'b0);
            return;
        end
        if (mal) begin
            chkb("mis_pulse", mis, 1'b1);
            chkb("mis_req", bus.mem_req_o, 1'b0);
            chkb("mis_stall", stall, 1'b0);
            step(); #1;
            chkb("mis_once", mis, 1'b0);
            chkb("mis_req2", bus.mem_req_o, 1'b0);
            return;
        end
        if (scf) begin
            chkb("scf_done", done, 1'b1);
            chkb("scf_req", bus.mem_req_o, 1'b0);
            step(); #1;
            chkb("scf_done_once", done, 1'b0);
            return;
        end
        for (int i = 0; i <= gdel; i++) begin
            chkb("req", bus.mem_req_o, 1'b1);
            chkb("req_stall", stall, 1'b1);
            chkb("req_done", done, 1'b0);
            chk("req_addr", bus.mem_address_o, a & 32'hFFFF_FFFC);
            chk("req_we", 32'(bus.mem_we_o), 32'(m_we(o, a)));
            if (m_store(o)) chk("req_data", bus.mem_data_o, m_wd(o, d));
            if (i == 0 && fmode == 1) begin
                flush = 1'b1;
                if (gdel == 0) begin
                    bus.mem_gnt_i = 1'b1;
                    aborted = 1;
                end else begin
                    cancelled = 1;
                end
            end else if (i == gdel) begin
                bus.mem_gnt_i = 1'b1;
            end
            step();
            flush = 1'b0;
            bus.mem_gnt_i = 1'b0;
            #1;
            if (cancelled) break;
        end
        if (cancelled) begin
            chkb("cancel_req", bus.mem_req_o, 1'b0);
            chkb("cancel_stall", stall, 1'b0);
            chkb("cancel_done", done, 1'b0);
            step(); #1;
            chkb("cancel_done2", done, 1'b0);
            return;
        end
        for (int j = 1; j <= rdel; j++) begin
            chkb("wait_req", bus.mem_req_o, 1'b0);
            chkb("wait_stall", stall, 1'b1);
            chkb("wait_done", done, 1'b0);
            if (j == 1 && fmode == 2) begin
                flush = 1'b1;
                aborted = 1;
            end
            if (j == rdel) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_data_i = rdata;
            end
            step();
            flush = 1'b0;
            bus.mem_rvalid_i = 1'b0;
            bus.mem_data_i = $urandom;
            #1;
        end
        if (!aborted && m_load(o)) exp_ld = rdata;
        chkb("done", done, !aborted);
        chk("load_data", ld, exp_ld);
        chkb("done_stall", stall, 1'b0);
        step(); #1;
        chkb("done_once", done, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; valid = 1'b0; valid2 = 1'b0; sc_allow = 1'b0; flush = 1'b0;
        op = NOP; addr = '0; wdata = '0;
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_data_i = '0;
        bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b0; bus2.mem_data_i = '0;
        repeat (2) @(posedge clk);
        #2;
        chkb("rst_req", bus.mem_req_o, 1'b0);
        chkb("rst_stall", stall, 1'b0);
        chkb("rst_done", done, 1'b0);
        chk("rst_ld", ld, 32'h0);
        chk("rst_addr", bus.mem_address_o, 32'h0);
        chk("rst_we", 32'(bus.mem_we_o), 32'h0);
        chkb("rst_fault", fault, 1'b0);
        reset_n = 1'b1;

        do_txn(LW, 32'h100, 32'h0, 1'b0, 0, 1, 32'hDEADBEEF, 0);
        do_txn(SB, 32'h203, 32'h12345678, 1'b0, 0, 1, 32'h0, 0);
        do_txn(LH, 32'h101, 32'h0, 1'b0, 0, 1, 32'h0, 0);
        do_txn(LW, 32'h180, 32'h0, 1'b0, 3, 2, 32'h0BADF00D, 0);
        do_txn(LW, 32'h104, 32'h0, 1'b0, 0, 2, 32'hCAFEF00D, 2);
        do_txn(LW, 32'h108, 32'h0, 1'b0, 0, 1, 32'h13572468, 0);
        do_txn(SH, 32'h222, 32'hA5A5BEEF, 1'b0, 1, 1, 32'h0, 0);
        do_txn(SC_W, 32'h300, 32'h77, 1'b0, 0, 1, 32'h0, 0);
        do_txn(SC_W, 32'h304, 32'h88, 1'b1, 0, 1, 32'h0, 0);
        do_txn(LBU, 32'h10F, 32'h0, 1'b0, 2, 1, 32'h00C0FFEE, 1);
        do_txn(SW, 32'h402, 32'h0, 1'b0, 0, 1, 32'h0, 0);
        do_txn(NOP, 32'h0, 32'h0, 1'b0, 0, 1, 32'h0, 0);

        step();
        flush = 1'b1;
        #1;
        chkb("idle_flush_stall", stall, 1'b0);
        step();
        flush = 1'b0;
        #1;
        chkb("idle_flush_req", bus.mem_req_o, 1'b0);
        chkb("idle_flush_done", done, 1'b0);
        do_txn(LW, 32'h500, 32'h0, 1'b0, 0, 1, 32'h600DCAFE, 0);

        for (int n = 0; n < 40; n++) begin
            iType_e      ro;
            logic [31:0] ra;
            int          fm;
            ro = iType_e'(4'($urandom_range(0, 10)));
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
            fm = int'($urandom_range(0, 5));
            if (fm > 2) fm = 0;
            do_txn(ro, ra, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)), $urandom, fm);
        end

        step();
        op = LW; addr = 32'h300; valid = 1'b1;
        #1;
        step();
        valid = 1'b0;
        #1;
        chkb("pre_reset_req", bus.mem_req_o, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chkb("async_rst_req", bus.mem_req_o, 1'b0);
        chkb("async_rst_stall", stall, 1'b0);
        chk("async_rst_addr", bus.mem_address_o, 32'h0);
        chk("async_rst_ld", ld, 32'h0);
        exp_ld = 32'h0;
        step();
        reset_n = 1'b1;
        do_txn(LW, 32'h700, 32'h0, 1'b0, 0, 1, 32'h11223344, 0);

        step();
        op = LW; addr = 32'h40; valid2 = 1'b1;
        #1;
        chkb("to_stall_accept", stall2, 1'b1);
        step();
        valid2 = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            chkb("to_req", bus2.mem_req_o, 1'b1);
            chkb("to_no_fault_yet", fault2, 1'b0);
            step();
        end
        chkb("to_fault", fault2, 1'b1);
        chkb("to_req_drop", bus2.mem_req_o, 1'b0);
        chkb("to_stall_drop", stall2, 1'b0);
        step();
        bus2.mem_rvalid_i = 1'b1;
        bus2.mem_data_i = 32'h99999999;
        #1;
        chkb("to_fault_once", fault2, 1'b0);
        step();
        bus2.mem_rvalid_i = 1'b0;
        #1;
        chkb("to_late_rvalid", done2, 1'b0);
        chk("to_late_ld", ld2, 32'h0);

        step();
        op = LW; addr = 32'h44; valid2 = 1'b1;
        #1;
        step();
        valid2 = 1'b0;
        bus2.mem_gnt_i = 1'b1;
        #1;
        chkb("race_req", bus2.mem_req_o, 1'b1);
        step();
        bus2.mem_gnt_i = 1'b0;
        #1;
        chkb("race_wait_stall", stall2, 1'b1);
        step();
        #1;
        chkb("race_wait_stall2", stall2, 1'b1);
        step();
        bus2.mem_rvalid_i = 1'b1;
        bus2.mem_data_i = 32'h55AA1234;
        #1;
        step();
        bus2.mem_rvalid_i = 1'b0;
        #1;
        chkb("race_done", done2, 1'b1);
        chkb("race_no_fault", fault2, 1'b0);
        chk("race_ld", ld2, 32'h55AA1234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
